// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared definitions for the register-file port arbiter.
//   - arb_state_e : arbiter state encoding (idle / owned by requester 0 / 1)
//   - RF_AW/RF_DW : default RF address/data widths shared with the RF and calculator FSM
//   - RF_NOP_ADDR : address driven to the RF when nobody owns the port set
//   - sat_inc8    : 8-bit saturating increment used by the hold timer and statistics
package rf_arb_pkg;

  localparam int unsigned RF_AW = 3;
  localparam int unsigned RF_DW = 8;

  localparam logic [RF_AW-1:0] RF_NOP_ADDR = '1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } arb_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/rf_arb_hold_timer.sv
// rf_arb_hold_timer: saturating count of cycles the current owner has kept the RF while
// the other requester waits, plus the compare that signals a preemption is due.
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_clr    : clear the count (has priority over i_inc)
//   i_inc    : count one more waiting cycle
//   o_expire : count has reached MAX_HOLD-1; switching at this edge gives MAX_HOLD cycles
module rf_arb_hold_timer
  import rf_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam logic [7:0] ExpireVal = 8'(MAX_HOLD - 1);

  logic [7:0] r_cnt_q;
  logic [7:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt_q;
    if (i_clr) begin
      w_cnt_d = '0;
    end else if (i_inc) begin
      w_cnt_d = sat_inc8(r_cnt_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt_q <= '0;
    end else begin
      r_cnt_q <= w_cnt_d;
    end
  end

  assign o_expire = (r_cnt_q == ExpireVal);

endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares one RF port set (2 read addresses, 1 write port) between the
// calculator control FSM (requester 0) and the display/debug scanner (requester 1).
// Round-robin on ties, grant held while req stays high, hold timer preempts a hog.
//   CLK, RST                     : clock (rising edge), synchronous active-high reset
//   reqN, weN, ra1_N, ra2_N, waN, wdN : requester N port set and request
//   gntN                          : requester N owns the RF (decoded from the state register)
//   rf_we, rf_ra1, rf_ra2, rf_wa, rf_wd : muxed port set to the RF
//   busy_out                      : either grant active
// Optional: define RF_ARB_STATS_EN to add grant_cnt0/grant_cnt1/preempt_cnt (8-bit, saturating).
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] ra1_0,
  input  logic [AW-1:0] ra2_0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  output logic          gnt0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] ra1_1,
  input  logic [AW-1:0] ra2_1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  output logic          gnt1,
  output logic          rf_we,
  output logic [AW-1:0] rf_ra1,
  output logic [AW-1:0] rf_ra2,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
`ifdef RF_ARB_STATS_EN
  output logic [7:0]    grant_cnt0,
  output logic [7:0]    grant_cnt1,
  output logic [7:0]    preempt_cnt,
`endif
  output logic          busy_out
);

  arb_state_e r_state_q;
  arb_state_e w_state_d;
  logic       r_last_owner_q;  // 1 after reset so requester 0 wins the first tie
  logic       w_expire;
  logic       w_preempt;
  logic       w_other_req;

  always_comb begin
    w_state_d = r_state_q;
    w_preempt = 1'b0;
    unique case (r_state_q)
      StIdle: begin
        if (req0 && (!req1 || r_last_owner_q)) begin
          w_state_d = StOwn0;
        end else if (req1) begin
          w_state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!req0) begin
          w_state_d = req1 ? StOwn1 : StIdle;
        end else if (req1 && w_expire) begin
          w_state_d = StOwn1;
          w_preempt = 1'b1;
        end
      end
      StOwn1: begin
        if (!req1) begin
          w_state_d = req0 ? StOwn0 : StIdle;
        end else if (req0 && w_expire) begin
          w_state_d = StOwn0;
          w_preempt = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state_q      <= StIdle;
      r_last_owner_q <= 1'b1;
    end else begin
      r_state_q <= w_state_d;
      if (w_state_d != r_state_q && w_state_d == StOwn0) r_last_owner_q <= 1'b0;
      if (w_state_d != r_state_q && w_state_d == StOwn1) r_last_owner_q <= 1'b1;
    end
  end

  // The non-owner's request; never set while idle, so the timer stays cleared there.
  assign w_other_req = (r_state_q == StOwn0) ? req1 :
                       (r_state_q == StOwn1) ? req0 : 1'b0;

  rf_arb_hold_timer #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold_timer (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   ((w_state_d != r_state_q) || !w_other_req),
    .i_inc   (w_other_req),
    .o_expire(w_expire)
  );

  assign gnt0     = (r_state_q == StOwn0);
  assign gnt1     = (r_state_q == StOwn1);
  assign busy_out = gnt0 | gnt1;

  // Port mux follows the registered state, so a new owner drives the RF in the same cycle
  // its grant rises and the previous owner is cut off that cycle.
  always_comb begin
    rf_we  = 1'b0;
    rf_ra1 = '1;
    rf_ra2 = '1;
    rf_wa  = '1;
    rf_wd  = '0;
    unique case (r_state_q)
      StOwn0: begin
        rf_we  = we0 & req0;
        rf_ra1 = ra1_0;
        rf_ra2 = ra2_0;
        rf_wa  = wa0;
        rf_wd  = wd0;
      end
      StOwn1: begin
        rf_we  = we1 & req1;
        rf_ra1 = ra1_1;
        rf_ra2 = ra2_1;
        rf_wa  = wa1;
        rf_wd  = wd1;
      end
      default: ;
    endcase
  end

`ifdef RF_ARB_STATS_EN
  logic [7:0] r_grant_cnt0_q;
  logic [7:0] r_grant_cnt1_q;
  logic [7:0] r_preempt_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant_cnt0_q  <= '0;
      r_grant_cnt1_q  <= '0;
      r_preempt_cnt_q <= '0;
    end else begin
      if (w_state_d == StOwn0 && r_state_q != StOwn0) r_grant_cnt0_q <= sat_inc8(r_grant_cnt0_q);
      if (w_state_d == StOwn1 && r_state_q != StOwn1) r_grant_cnt1_q <= sat_inc8(r_grant_cnt1_q);
      if (w_preempt) r_preempt_cnt_q <= sat_inc8(r_preempt_cnt_q);
    end
  end

  assign grant_cnt0  = r_grant_cnt0_q;
  assign grant_cnt1  = r_grant_cnt1_q;
  assign preempt_cnt = r_preempt_cnt_q;
`endif

endmodule
